// File: rtl/imm_gen_pkg.sv
// imm_gen_pkg: shared format codes, opcode constants, the buffered entry
// layout and the raw 32-bit immediate extraction used by imm_gen_decode.
// Optional feature macro used by this codebase: IMM_GEN_ILLEGAL_EN.
package imm_gen_pkg;

  // Resolved immediate formats; IMM_RSV marks an unknown/reserved format
  // internally and is always reported on the output as IMM_R.
  typedef enum logic [2:0] {
    IMM_I   = 3'd0,
    IMM_S   = 3'd1,
    IMM_B   = 3'd2,
    IMM_U   = 3'd3,
    IMM_J   = 3'd4,
    IMM_Z   = 3'd5,
    IMM_R   = 3'd6,
    IMM_RSV = 3'd7
  } imm_fmt_e;

  // Entry slots are sized for the widest legal configuration; narrower
  // configurations keep the upper bits at zero.
  localparam int IMM_XLEN_MAX = 64;
  localparam int IMM_TAG_MAX  = 16;

  // Major opcodes (instr[6:0]).
  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  // One buffered result: immediate, resolved format, sideband tag, illegal flag.
  typedef struct packed {
    logic [IMM_XLEN_MAX-1:0] imm;
    imm_fmt_e                fmt;
    logic [IMM_TAG_MAX-1:0]  tag;
    logic                    illegal;
  } imm_entry_t;

  // Raw immediate as a 32-bit value whose bit 31 is the sign to extend from
  // (Z keeps bit 31 clear, so sign extension equals zero extension there).
  function automatic logic [31:0] imm32_of(input imm_fmt_e f, input logic [31:0] i);
    logic [31:0] r;
    r = 32'h0;
    case (f)
      IMM_I:   r = {{20{i[31]}}, i[31:20]};
      IMM_S:   r = {{20{i[31]}}, i[31:25], i[11:7]};
      IMM_B:   r = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      IMM_U:   r = {i[31:12], 12'h000};
      IMM_J:   r = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      IMM_Z:   r = {27'h0, i[19:15]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/imm_gen_decode.sv
// imm_gen_decode: combinational format resolution and immediate extraction.
// With IMM_GEN_ILLEGAL_EN defined, unknown opcodes, reserved explicit formats
// and non-32-bit encodings (instr[1:0] != 2'b11) are flagged illegal.
module imm_gen_decode
  import imm_gen_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      fmt_sel,
  input  logic            auto_en,
  output logic [XLEN-1:0] imm,
  output imm_fmt_e        fmt,
  output logic            illegal
);

  imm_fmt_e    auto_fmt;
  imm_fmt_e    sel_fmt;
  logic        no_imm;
  logic        zero_out;
  logic [31:0] raw32;

  // Opcode-driven format; RV64-only opcodes are unknown on RV32.
  always_comb begin
    auto_fmt = IMM_RSV;
    case (instr[6:0])
      OPC_OP_IMM, OPC_LOAD, OPC_JALR, OPC_MISC_MEM: auto_fmt = IMM_I;
      OPC_OP_IMM_32: auto_fmt = (XLEN == 64) ? IMM_I : IMM_RSV;
      OPC_SYSTEM:    auto_fmt = instr[14] ? IMM_Z : IMM_I;
      OPC_STORE:     auto_fmt = IMM_S;
      OPC_BRANCH:    auto_fmt = IMM_B;
      OPC_LUI, OPC_AUIPC: auto_fmt = IMM_U;
      OPC_JAL:       auto_fmt = IMM_J;
      OPC_OP:        auto_fmt = IMM_R;
      OPC_OP_32:     auto_fmt = (XLEN == 64) ? IMM_R : IMM_RSV;
      default:       auto_fmt = IMM_RSV;
    endcase
  end

  assign sel_fmt = auto_en ? auto_fmt : imm_fmt_e'(fmt_sel);
  assign no_imm  = (sel_fmt == IMM_R) || (sel_fmt == IMM_RSV);

`ifdef IMM_GEN_ILLEGAL_EN
  // Auto R-type is legal (it simply has no immediate); explicit 6/7 is not.
  logic bad_fmt;
  assign bad_fmt = auto_en ? (auto_fmt == IMM_RSV) : (fmt_sel[2:1] == 2'b11);
  assign illegal = bad_fmt || (instr[1:0] != 2'b11);
`else
  assign illegal = 1'b0;
`endif

  // Anything without a usable immediate reports R with a zero immediate.
  assign zero_out = no_imm || illegal;
  assign raw32    = imm32_of(sel_fmt, instr);
  assign fmt      = zero_out ? IMM_R : sel_fmt;
  assign imm      = zero_out ? '0 : XLEN'($signed(raw32));

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: registered immediate generator behind a two-slot skid buffer.
// Slot "out" drives the outputs; slot "skid" catches one extra instruction
// while the consumer stalls. FIFO order is preserved and in_ready is simply
// the registered inverse of the skid valid bit.
// Optional feature macro: IMM_GEN_ILLEGAL_EN (illegal-entry flagging).
// TAG_W must not exceed IMM_TAG_MAX and XLEN must be 32 or 64.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; a producer holding valid may not assume acceptance until then,
// and out_* fields are held stable while out_valid is high and out_ready low.
module imm_gen_pipe
  import imm_gen_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [2:0]       in_type,
  input  logic             in_auto,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  logic [XLEN-1:0] dec_imm;
  imm_fmt_e        dec_fmt;
  logic            dec_illegal;

  imm_entry_t in_entry;
  imm_entry_t out_q;
  imm_entry_t skid_q;
  logic       out_v;
  logic       skid_v;
  logic       take_in;
  logic       take_out;

  imm_gen_decode #(
    .XLEN (XLEN)
  ) u_decode (
    .instr   (in_instr),
    .fmt_sel (in_type),
    .auto_en (in_auto),
    .imm     (dec_imm),
    .fmt     (dec_fmt),
    .illegal (dec_illegal)
  );

  // Pack the freshly decoded result into the common entry layout.
  always_comb begin
    in_entry         = '0;
    in_entry.imm     = IMM_XLEN_MAX'(dec_imm);
    in_entry.fmt     = dec_fmt;
    in_entry.tag     = IMM_TAG_MAX'(in_tag);
    in_entry.illegal = dec_illegal;
  end

  assign in_ready = ~skid_v;
  assign take_in  = in_valid & in_ready;
  assign take_out = out_v & out_ready;

  // Skid buffer: out slot refills from skid first, then from the input;
  // the skid only fills when the out slot is occupied and not draining.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (take_out && skid_v) begin
        out_q <= skid_q;
        if (take_in) begin
          skid_q <= in_entry;
        end else begin
          skid_v <= 1'b0;
        end
      end else if (take_out) begin
        if (take_in) begin
          out_q <= in_entry;
        end else begin
          out_v <= 1'b0;
        end
      end else if (take_in) begin
        if (!out_v) begin
          out_q <= in_entry;
          out_v <= 1'b1;
        end else begin
          skid_q <= in_entry;
          skid_v <= 1'b1;
        end
      end
    end
  end

  assign out_valid   = out_v;
  assign out_imm     = out_q.imm[XLEN-1:0];
  assign out_type    = out_q.fmt;
  assign out_tag     = out_q.tag[TAG_W-1:0];
  assign out_illegal = out_q.illegal;

  // Slot bits above XLEN/TAG_W are always zero; folding them here marks
  // them as deliberately unread.
  logic unused_slot_bits;
  assign unused_slot_bits = ^{out_q.imm, out_q.tag};

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb_imm_gen_pipe: directed and randomized checks of imm_gen_pipe at XLEN=64
// and XLEN=32 (both instances share one input stream and handshake).
module tb_imm_gen_pipe;

  localparam int TAG_W = 5;
  localparam int TW    = TAG_W + 36;   // {tag, auto, type, instr}

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_ready32;
  logic [31:0]      in_instr;
  logic [2:0]       in_type;
  logic             in_auto;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_valid32;
  logic             out_ready;
  logic [63:0]      out_imm;
  logic [31:0]      out_imm32;
  logic [2:0]       out_type;
  logic [2:0]       out_type32;
  logic [TAG_W-1:0] out_tag;
  logic [TAG_W-1:0] out_tag32;
  logic             out_illegal;
  logic             out_illegal32;

  int n_cmp = 0;
  int n_err = 0;

  // Accepted transactions in order; expectations are derived at delivery.
  logic [TW-1:0]    exp_q[$];
  logic [TAG_W-1:0] got_tags[$];
  logic             log_tags = 1'b0;

  logic             have_prev = 1'b0;
  logic [63:0]      prev_imm;
  logic [2:0]       prev_type;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_ill;

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_type(in_type), .in_auto(in_auto), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_imm(out_imm), .out_type(out_type), .out_tag(out_tag),
    .out_illegal(out_illegal)
  );

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready32),
    .in_instr(in_instr), .in_type(in_type), .in_auto(in_auto), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready),
    .out_imm(out_imm32), .out_type(out_type32), .out_tag(out_tag32),
    .out_illegal(out_illegal32)
  );

  // Clock and reset level
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: immediate value from the format rules using plain arithmetic.
  // Returns {illegal, type[2:0], imm[63:0]} with imm truncated to xlen bits.
  function automatic logic [67:0] model(input logic [31:0] i, input logic [2:0] t,
                                        input logic a, input int xlen);
    int          fmt;
    logic        ill;
    longint      v;
    logic [63:0] r;
    fmt = int'(t);
    if (a) begin
      case (i[6:0])
        7'h13, 7'h03, 7'h67, 7'h0F: fmt = 0;
        7'h1B: fmt = (xlen == 64) ? 0 : 7;
        7'h73: fmt = i[14] ? 5 : 0;
        7'h23: fmt = 1;
        7'h63: fmt = 2;
        7'h37, 7'h17: fmt = 3;
        7'h6F: fmt = 4;
        7'h33: fmt = 6;
        7'h3B: fmt = (xlen == 64) ? 6 : 7;
        default: fmt = 7;
      endcase
    end
    ill = 1'b0;
`ifdef IMM_GEN_ILLEGAL_EN
    ill = (a ? (fmt == 7) : (t >= 3'd6)) || (i[1:0] != 2'b11);
`endif
    v = 0;
    case (fmt)
      0: v = longint'($signed(i)) >>> 20;
      1: begin
        v = longint'($signed(i)) >>> 25;
        v = v * 32 + longint'(i[11:7]);
      end
      2: begin
        v = i[31] ? -64'sd4096 : 64'sd0;
        v = v + longint'(i[7]) * 2048 + longint'(i[30:25]) * 32 + longint'(i[11:8]) * 2;
      end
      3: v = (longint'($signed(i)) >>> 12) * 4096;
      4: begin
        v = i[31] ? -64'sd1048576 : 64'sd0;
        v = v + longint'(i[19:12]) * 4096 + longint'(i[20]) * 2048 + longint'(i[30:21]) * 2;
      end
      5: v = longint'(i[19:15]);
      default: v = 0;
    endcase
    if (fmt >= 6 || ill) begin
      v   = 0;
      fmt = 6;
    end
    r = v;
    if (xlen == 32) r[63:32] = 32'h0;
    return {ill, 3'(fmt), r};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0]  ops [16] = '{7'h13, 7'h03, 7'h67, 7'h0F, 7'h1B, 7'h73, 7'h73, 7'h23,
                              7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h3B, 7'h7F, 7'h0B};
    logic [31:0] r;
    r = $urandom();
    r[6:0] = ops[$urandom_range(0, 15)];
    if ($urandom_range(0, 7) == 0) r[1:0] = 2'($urandom_range(0, 2));
    return r;
  endfunction

  // Scoreboard: occupancy, stall stability and delivered-entry checks,
  // sampled on the falling edge ahead of the next rising edge.
  task automatic check_outputs();
    logic [TW-1:0] e;
    logic [67:0]   m64;
    logic [67:0]   m32;
    chk("out_valid", 64'(out_valid), 64'(exp_q.size() != 0));
    chk("in_ready", 64'(in_ready), 64'(exp_q.size() < 2));
    chk("out_valid32", 64'(out_valid32), 64'(exp_q.size() != 0));
    chk("in_ready32", 64'(in_ready32), 64'(exp_q.size() < 2));
    if (have_prev) begin
      chk("hold_imm", out_imm, prev_imm);
      chk("hold_type", 64'(out_type), 64'(prev_type));
      chk("hold_tag", 64'(out_tag), 64'(prev_tag));
      chk("hold_ill", 64'(out_illegal), 64'(prev_ill));
    end
    have_prev = out_valid && !out_ready;
    prev_imm  = out_imm;
    prev_type = out_type;
    prev_tag  = out_tag;
    prev_ill  = out_illegal;
    if (out_valid && out_ready && exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      m64 = model(e[31:0], e[34:32], e[35], 64);
      m32 = model(e[31:0], e[34:32], e[35], 32);
      chk("imm64", out_imm, m64[63:0]);
      chk("type64", 64'(out_type), 64'(m64[66:64]));
      chk("tag64", 64'(out_tag), 64'(e[TW-1:36]));
      chk("ill64", 64'(out_illegal), 64'(m64[67]));
      chk("imm32", 64'(out_imm32), m32[63:0]);
      chk("type32", 64'(out_type32), 64'(m32[66:64]));
      chk("tag32", 64'(out_tag32), 64'(e[TW-1:36]));
      chk("ill32", 64'(out_illegal32), 64'(m32[67]));
      if (log_tags) got_tags.push_back(out_tag);
    end
  endtask

  // One clock: check at the falling edge, record acceptance, advance.
  task automatic cycle();
    check_outputs();
    if (in_valid && in_ready) exp_q.push_back({in_tag, in_auto, in_type, in_instr});
    @(posedge clk);
    @(negedge clk);
  endtask

  // Driver: present one instruction with the consumer ready.
  task automatic send(input logic [31:0] instr, input logic [2:0] t, input logic a,
                      input logic [TAG_W-1:0] tag);
    in_instr  = instr;
    in_type   = t;
    in_auto   = a;
    in_tag    = tag;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    cycle();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_instr  = 32'h0;
    in_type   = 3'd0;
    in_auto   = 1'b0;
    in_tag    = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_in_ready", 64'(in_ready), 64'h1);
    chk("rst_out_imm", out_imm, 64'h0);
    chk("rst_out_type", 64'(out_type), 64'h0);
    chk("rst_out_tag", 64'(out_tag), 64'h0);
    chk("rst_out_ill", 64'(out_illegal), 64'h0);
    rst_n = 1'b1;
    cycle();

    // Explicit I: all-ones immediate, tag echoed, one-cycle latency
    send(32'hFFF00093, 3'd0, 1'b0, 5'd5);
    chk("dir_i_valid", 64'(out_valid), 64'h1);
    chk("dir_i_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("dir_i_type", 64'(out_type), 64'h0);
    chk("dir_i_tag", 64'(out_tag), 64'h5);
    cycle();

    // Auto B: backward branch by -4
    send(32'hFE000EE3, 3'd7, 1'b1, 5'd6);
    chk("dir_b_type", 64'(out_type), 64'h2);
    chk("dir_b_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFC);
    cycle();

    // Auto U: sign extension from bit 31 differs between XLEN 64 and 32
    send(32'h800000B7, 3'd0, 1'b1, 5'd7);
    chk("dir_u_imm64", out_imm, 64'hFFFF_FFFF_8000_0000);
    chk("dir_u_imm32", 64'(out_imm32), 64'h8000_0000);
    chk("dir_u_type", 64'(out_type), 64'h3);
    cycle();

    // Auto Z: CSR immediate form
    send(32'h300FD073, 3'd0, 1'b1, 5'd8);
    chk("dir_z_type", 64'(out_type), 64'h5);
    chk("dir_z_imm", out_imm, 64'h1F);
    cycle();

    // Unknown opcode
    send(32'h0000007F, 3'd0, 1'b1, 5'd9);
    chk("dir_unk_imm", out_imm, 64'h0);
    chk("dir_unk_type", 64'(out_type), 64'h6);
`ifdef IMM_GEN_ILLEGAL_EN
    chk("dir_unk_ill", 64'(out_illegal), 64'h1);
`else
    chk("dir_unk_ill", 64'(out_illegal), 64'h0);
`endif
    cycle();

    // Backpressure: tags 1,2 accepted, 3 held until the skid drains
    got_tags.delete();
    log_tags  = 1'b1;
    out_ready = 1'b0;
    in_instr  = 32'h00100093;
    in_type   = 3'd0;
    in_auto   = 1'b1;
    in_valid  = 1'b1;
    in_tag    = 5'd1;
    cycle();
    in_tag    = 5'd2;
    cycle();
    in_tag    = 5'd3;
    chk("bp_in_ready_low", 64'(in_ready), 64'h0);
    cycle();
    chk("bp_held_tag", 64'(out_tag), 64'h1);
    chk("bp_still_full", 64'(in_ready), 64'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && in_valid; k++) begin
      logic acc;
      acc = in_ready;
      cycle();
      if (acc) in_valid = 1'b0;
    end
    chk("bp_third_accepted", 64'(in_valid), 64'h0);
    repeat (3) cycle();
    log_tags = 1'b0;
    chk("bp_count", 64'(got_tags.size()), 64'd3);
    if (got_tags.size() == 3) begin
      chk("bp_order0", 64'(got_tags[0]), 64'd1);
      chk("bp_order1", 64'(got_tags[1]), 64'd2);
      chk("bp_order2", 64'(got_tags[2]), 64'd3);
    end

    // Asynchronous reset with both slots full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd10;
    cycle();
    in_tag    = 5'd11;
    cycle();
    in_valid  = 1'b0;
    chk("ar_full", 64'(in_ready), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'h0);
    chk("ar_in_ready", 64'(in_ready), 64'h1);
    chk("ar_out_tag", 64'(out_tag), 64'h0);
    exp_q.delete();
    have_prev = 1'b0;
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (4) cycle();

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      in_instr  = rand_instr();
      in_type   = 3'($urandom_range(0, 7));
      in_auto   = 1'($urandom_range(0, 1));
      in_tag    = TAG_W'($urandom());
      out_ready = ($urandom_range(0, 3) != 0);
      cycle();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) cycle();
    chk("drain_empty", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/imm_gen_pipe.md
# imm_gen_pipe

Pipelined, parametrised immediate generator for the RV32/RV64 datapath. It takes a 32-bit instruction through a valid/ready handshake and produces the XLEN-wide immediate one cycle later. The format is either supplied explicitly or derived from the opcode. A two-entry skid buffer sits between decode and the execute-stage operand mux, so backpressure never drops or duplicates an instruction.

## Interface
Parameters:
- XLEN, 64: datapath width; legal values 32 and 64.
- TAG_W, 5: width of the sideband tag carried alongside each instruction (e.g. ROB/PC index).

Ports:
- clk  in  1  system clock; one clock, all state on rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  instruction present.
- in_ready  out  1  block can accept; equals NOT skid_valid (registered).
- in_instr  in  32  raw instruction.
- in_type  in  3  explicit format: 0 I, 1 S, 2 B, 3 U, 4 J, 5 Z (CSR zimm); 6/7 reserved.
- in_auto  in  1  1 = derive format from opcode, ignore in_type.
- in_tag  in  TAG_W  sideband, passed through unchanged.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts.
- out_imm  out  XLEN  generated immediate.
- out_type  out  3  resolved format (6 = R/no immediate).
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  unrecognised format (see Configuration).

## Operation
- Formats: I sext(i[31:20]); S sext(i[31:25],i[11:7]); B sext(i[31],i[7],i[30:25],i[11:8],0); J sext(i[31],i[19:12],i[20],i[30:21],0); U i[31:12]<<12, sign-extended from bit 31 to XLEN; Z zero-extend(i[19:15]).
- Auto decode (opcode i[6:0]):
  - 0010011, 0000011, 1100111, 0001111 → I.
  - 0011011 → I, only when XLEN=64.
  - 1110011 → Z if i[14]=1, else I.
  - 0100011 → S. 1100011 → B. 0110111, 0010111 → U. 1101111 → J.
  - 0110011, 0111011 (latter only when XLEN=64) → R.
  - Anything else → unknown.
- R and unknown/reserved produce imm 0 with out_type 6.
- Buffer:
  - Transfer in = in_valid & in_ready. Transfer out = out_valid & out_ready.
  - On transfer in: load the output register if it is empty or being drained this cycle; otherwise load the skid register.
  - On transfer out with skid valid: skid moves to output; skid is refilled the same cycle if a transfer in occurs.
- Order is strictly FIFO. A simultaneous in/out transfer with output full and skid empty keeps the skid empty.

## Timing
- Latency: 1 cycle from transfer in to out_valid when unblocked. Throughput 1 per cycle.
- in_ready deasserts the cycle after the skid fills and reasserts the cycle after it drains.
- Output fields stay stable while out_valid & !out_ready.
- Reset values: out_valid 0, skid empty, in_ready 1, out_imm 0, out_type 0, out_tag 0, out_illegal 0.
- Reset mid-operation clears both slots immediately (asynchronous); in-flight entries are discarded, not replayed.

## Configuration
- IMM_GEN_ILLEGAL_EN defined:
  - out_illegal=1 for an unknown opcode (auto mode), in_type 6/7 (explicit mode), or i[1:0]≠11.
  - out_illegal is registered and buffered with its entry.
  - out_imm is forced to 0 for such entries.
- IMM_GEN_ILLEGAL_EN undefined: out_illegal is tied 0; the same cases still give imm 0 and type 6.

## Structure
- Package imm_gen_pkg holds:
  - Format codes: IMM_I..IMM_Z, IMM_R=6.
  - Opcode constants.
  - An entry struct {imm, type, tag, illegal}.
- Sub-module imm_gen_decode: purely combinational extraction/decode, parametrised by XLEN.
- The top module holds the two-slot skid buffer and the handshake.

## Test plan
- Explicit I, XLEN=64: in_instr 0xFFF00093, in_type 0 → next cycle out_imm 0xFFFFFFFFFFFFFFFF, out_type 0, tag echoed.
- Auto B: 0xFE000EE3 → out_type 2, out_imm 0xFFFFFFFFFFFFFFFC.
- Auto U: 0x800000B7 → XLEN=64 gives 0xFFFFFFFF80000000; XLEN=32 gives 0x80000000.
- Auto Z: 0x300FD073 → out_type 5, out_imm 0x1F. 0x0000007F → with IMM_GEN_ILLEGAL_EN, out_illegal 1 and imm 0; without, out_illegal 0 and out_type 6.
- Backpressure: out_ready=0, three back-to-back inputs with tags 1,2,3 → first two accepted, in_ready low the cycle after the second, third held. Raise out_ready → tags 1,2,3 delivered in order, no duplicates.
- Both slots full, rst_n pulsed low mid-cycle → out_valid 0 immediately; in_ready 1 after release; no stale entry emerges.
